// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates load/ALU results into a small FIFO, drains one
// register-file write per cycle, and tracks per-register write-pending busy bits.
module regfile_wb_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NREG   = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic [NREG-1:0]   busy,
   output logic              write,
   output logic [ADDR_W-1:0] wr_Addr,
   output logic [DATA_W-1:0] wr_Data,
   output logic              empty,
   output logic [7:0]        err_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic [7:0]        err_q, err_d;

   logic              full, fifo_empty, pop, push, bad;
   logic              ld_fire, alu_fire, acc, in_range, issue_fire;
   logic [ADDR_W-1:0] in_addr, head_addr;
   logic [DATA_W-1:0] in_data;
   logic [NREG-1:0]   issue_hit, clr_hit;

   assign full       = (count_q == CW'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign pop        = !fifo_empty;
   assign head_addr  = addr_mem[rptr_q];

   // Load path has fixed priority; ALU is only offered the slot when no load is valid.
   always_comb begin
      ld_ready  = !full;
      alu_ready = !full && !ld_valid;
      ld_fire   = ld_valid && ld_ready;
      alu_fire  = alu_valid && alu_ready;
      acc       = ld_fire || alu_fire;
      in_addr   = ld_fire ? ld_addr : alu_addr;
      in_data   = ld_fire ? ld_data : alu_data;
      in_range  = ({1'b0, in_addr} < (ADDR_W + 1)'(NREG));
      push      = acc && in_range;
      bad       = acc && !in_range;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_busy
         assign issue_hit[gi] = (issue_addr == ADDR_W'(gi));
         assign clr_hit[gi]   = pop && (head_addr == ADDR_W'(gi));
      end
   endgenerate

   // Only in-range addresses produce a hit, so out-of-range issues are never ready.
   assign issue_ready = |(issue_hit & ~busy_q);
   assign issue_fire  = issue_valid && issue_ready;

   always_comb begin
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);
      // Set after clear so a same-edge set on the popped register wins.
      busy_d = (busy_q & ~clr_hit) | (issue_hit & {NREG{issue_fire}});
      err_d  = (bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         busy_q  <= '0;
         err_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wptr_q] <= in_addr;
         data_mem[wptr_q] <= in_data;
      end
   end

   assign write     = pop;
   assign wr_Addr   = pop ? head_addr : '0;
   assign wr_Data   = pop ? data_mem[rptr_q] : '0;
   assign empty     = fifo_empty;
   assign busy      = busy_q;
   assign err_count = err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: accepted results are queued at the
// negedge before the capturing edge and compared as writes appear.
module tb_regfile_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid, alu_valid, issue_valid;
   logic        ld_ready, alu_ready, issue_ready;
   logic [2:0]  ld_addr, alu_addr, issue_addr;
   logic [15:0] ld_data, alu_data;
   logic [3:0]  busy;
   logic        write, empty;
   logic [2:0]  wr_Addr;
   logic [15:0] wr_Data;
   logic [7:0]  err_count;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0]  a;
      logic [15:0] d;
   } ent_t;

   ent_t       exp_q[$];
   ent_t       head_e, in_e;
   logic [3:0] m_busy, clr_m, set_m;
   logic [7:0] m_err;
   logic       acc_m, iss_ok;

   regfile_wb_ctrl dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_addr(issue_addr),
      .busy(busy), .write(write), .wr_Addr(wr_Addr), .wr_Data(wr_Data),
      .empty(empty), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ld_valid = 0; alu_valid = 0; issue_valid = 0;
      ld_addr = 0; alu_addr = 0; issue_addr = 0;
      ld_data = 0; alu_data = 0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      m_busy = '0;
      m_err  = '0;
   endtask

   // Outputs are checked against the model state, then the model advances to
   // what the coming rising edge should produce.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_write", 32'(write), 32'd0);
         chk("rst_empty", 32'(empty), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_ld_ready", 32'(ld_ready), 32'd1);
         clear_model();
      end else begin
         clr_m = '0;
         if (exp_q.size() > 0) begin
            head_e = exp_q.pop_front();
            chk("write", 32'(write), 32'd1);
            chk("wr_Addr", 32'(wr_Addr), 32'(head_e.a));
            chk("wr_Data", 32'(wr_Data), 32'(head_e.d));
            chk("empty", 32'(empty), 32'd0);
            clr_m = 4'b0001 << head_e.a[1:0];
         end else begin
            chk("idle_write", 32'(write), 32'd0);
            chk("idle_wr_Addr", 32'(wr_Addr), 32'd0);
            chk("idle_wr_Data", 32'(wr_Data), 32'd0);
            chk("idle_empty", 32'(empty), 32'd1);
         end
         chk("busy", 32'(busy), 32'(m_busy));
         chk("err_count", 32'(err_count), 32'(m_err));
         chk("ld_ready", 32'(ld_ready), 32'd1);
         chk("alu_ready", 32'(alu_ready), 32'(!ld_valid));
         iss_ok = (issue_addr < 3'd4) && !m_busy[issue_addr[1:0]];
         chk("issue_ready", 32'(issue_ready), 32'(iss_ok));
         set_m = (issue_valid && iss_ok) ? (4'b0001 << issue_addr[1:0]) : 4'b0000;
         m_busy = (m_busy & ~clr_m) | set_m;
         acc_m = 1'b0;
         if (ld_valid) begin
            acc_m = 1'b1; in_e.a = ld_addr; in_e.d = ld_data;
         end else if (alu_valid) begin
            acc_m = 1'b1; in_e.a = alu_addr; in_e.d = alu_data;
         end
         if (acc_m) begin
            if (in_e.a < 3'd4) exp_q.push_back(in_e);
            else if (m_err != 8'hFF) m_err = m_err + 8'd1;
         end
      end
   end

   initial begin
      clear_model();
      idle();
      rst = 1;
      repeat (3) cyc();
      rst = 0;
      cyc();

      // Single ALU result.
      alu_valid = 1; alu_addr = 3'd2; alu_data = 16'h1234;
      cyc();
      idle();
      chk("t1_write", 32'(write), 32'd1);
      chk("t1_data", 32'(wr_Data), 32'h1234);
      cyc();
      chk("t1_empty_after", 32'(empty), 32'd1);
      cyc();

      // Load and ALU together: load wins, ALU held one cycle.
      ld_valid = 1; ld_addr = 3'd1; ld_data = 16'hAAAA;
      alu_valid = 1; alu_addr = 3'd3; alu_data = 16'h5555;
      #1 chk("t2_alu_blocked", 32'(alu_ready), 32'd0);
      cyc();
      ld_valid = 0;
      chk("t2_ld_first", 32'(wr_Addr), 32'd1);
      #1 chk("t2_alu_now_ready", 32'(alu_ready), 32'd1);
      cyc();
      alu_valid = 0;
      chk("t2_alu_written", 32'(wr_Data), 32'h5555);
      repeat (2) cyc();

      // Back-to-back loads.
      for (int i = 0; i < 5; i++) begin
         ld_valid = 1; ld_addr = 3'(i % 4); ld_data = 16'(16'hC000 + i);
         cyc();
      end
      idle();
      repeat (2) cyc();

      // Scoreboard on r0.
      issue_valid = 1; issue_addr = 3'd0;
      cyc();
      issue_valid = 0;
      chk("t4_busy_set", 32'(busy), 32'h1);
      #1 chk("t4_reissue_blocked", 32'(issue_ready), 32'd0);
      alu_valid = 1; alu_addr = 3'd0; alu_data = 16'hBEEF;
      cyc();
      alu_valid = 0;
      chk("t4_busy_during_write", 32'(busy), 32'h1);
      cyc();
      chk("t4_busy_clear", 32'(busy), 32'h0);
      issue_valid = 1; issue_addr = 3'd0;
      #1 chk("t4_reissue_ok", 32'(issue_ready), 32'd1);
      cyc();
      issue_valid = 0; issue_addr = 3'd5;
      #1 chk("t4_issue_oob", 32'(issue_ready), 32'd0);
      cyc();

      // Out-of-range results and saturation.
      alu_valid = 1; alu_addr = 3'd5; alu_data = 16'hDEAD;
      cyc();
      alu_valid = 0;
      chk("t5_no_write", 32'(write), 32'd0);
      chk("t5_err1", 32'(err_count), 32'd1);
      alu_valid = 1;
      repeat (300) cyc();
      alu_valid = 0;
      chk("t5_err_sat", 32'(err_count), 32'd255);
      cyc();

      // Mid-stream async reset with busy=1011 and a write in flight.
      issue_valid = 1; issue_addr = 3'd1;
      cyc();
      issue_addr = 3'd3;
      cyc();
      issue_valid = 0;
      chk("t6_busy_1011", 32'(busy), 32'hB);
      ld_valid = 1; ld_addr = 3'd2; ld_data = 16'h7777;
      cyc();
      idle();
      #1 rst = 1;
      #1;
      chk("t6_rst_write", 32'(write), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_err", 32'(err_count), 32'd0);
      chk("t6_rst_empty", 32'(empty), 32'd1);
      clear_model();
      rst = 0;
      repeat (3) cyc();

      // Random mix.
      for (int i = 0; i < 200; i++) begin
         ld_valid    = ($urandom_range(0, 3) == 0);
         ld_addr     = 3'($urandom_range(0, 7));
         ld_data     = 16'($urandom);
         alu_valid   = ($urandom_range(0, 1) == 0);
         alu_addr    = 3'($urandom_range(0, 7));
         alu_data    = 16'($urandom);
         issue_valid = ($urandom_range(0, 2) == 0);
         issue_addr  = 3'($urandom_range(0, 4));
         cyc();
      end
      idle();
      repeat (3) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
